// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port synchronous D-MEM between the CPU MEM stage and a
// debug/loader port. CPU has priority; a starvation counter forces a debug slot.
module dmem_arbiter #(
    parameter int DBITS        = 32,
    parameter int DMEMADDRBITS = 16,
    parameter int DMEMWORDBITS = 2,
    parameter int MAXWAIT      = 4,
    parameter int CNTBITS      = 16
) (
    input  logic                                 clk,
    input  logic                                 RESET_N,
    input  logic                                 cpu_req,
    input  logic                                 cpu_we,
    input  logic [DBITS-1:0]                     cpu_addr,
    input  logic [DBITS-1:0]                     cpu_wdata,
    output logic                                 cpu_stall,
    output logic                                 cpu_rvalid,
    output logic [DBITS-1:0]                     cpu_rdata,
    input  logic                                 dbg_req,
    input  logic                                 dbg_we,
    input  logic [DBITS-1:0]                     dbg_addr,
    input  logic [DBITS-1:0]                     dbg_wdata,
    output logic                                 dbg_gnt,
    output logic                                 dbg_rvalid,
    output logic [DBITS-1:0]                     dbg_rdata,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]                     mem_wdata,
    input  logic [DBITS-1:0]                     mem_rdata,
    output logic [CNTBITS-1:0]                   conflict_cnt
);

    localparam int                 WAWIDTH  = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;
    localparam logic [WAWIDTH-1:0] WAIT_MAX = WAWIDTH'(MAXWAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DBG = 2'd2
    } rd_state_e;

    rd_state_e          state_q, state_d;
    logic [WAWIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNTBITS-1:0] conflict_q, conflict_d;
    logic [DBITS-1:0]   cpu_rdata_q, dbg_rdata_q;

    logic force_dbg;
    logic cpu_gnt_w;
    logic dbg_gnt_w;
    logic stall_w;

    // Address bits outside the decoded word field are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[DBITS-1:DMEMADDRBITS], cpu_addr[DMEMWORDBITS-1:0],
                                dbg_addr[DBITS-1:DMEMADDRBITS], dbg_addr[DMEMWORDBITS-1:0]};

    // Internal grants feed state; the port copies are forced low while in reset.
    always_comb begin
        force_dbg = dbg_req && (wait_cnt_q == WAIT_MAX);
        cpu_gnt_w = cpu_req && !force_dbg;
        dbg_gnt_w = dbg_req && (!cpu_req || force_dbg);
        stall_w   = cpu_req && !cpu_gnt_w;
    end

    assign dbg_gnt      = RESET_N & dbg_gnt_w;
    assign cpu_stall    = RESET_N & stall_w;
    assign conflict_cnt = conflict_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (RESET_N) begin
            if (cpu_gnt_w) begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr[DMEMADDRBITS-1:DMEMWORDBITS];
                mem_wdata = cpu_wdata;
            end else if (dbg_gnt_w) begin
                mem_en    = 1'b1;
                mem_we    = dbg_we;
                mem_addr  = dbg_addr[DMEMADDRBITS-1:DMEMWORDBITS];
                mem_wdata = dbg_wdata;
            end
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dbg_req || dbg_gnt_w) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAWIDTH'(1);
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (stall_w && (conflict_q != {CNTBITS{1'b1}})) begin
            conflict_d = conflict_q + CNTBITS'(1);
        end
    end

    // Read-return FSM: the state names which port owns the RAM data this cycle.
    always_comb begin
        state_d    = IDLE;
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
        cpu_rdata  = cpu_rdata_q;
        dbg_rdata  = dbg_rdata_q;

        case (state_q)
            RD_CPU: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = mem_rdata;
            end
            RD_DBG: begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = mem_rdata;
            end
            default: ;
        endcase

        if (cpu_gnt_w && !cpu_we) begin
            state_d = RD_CPU;
        end else if (dbg_gnt_w && !dbg_we) begin
            state_d = RD_DBG;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            conflict_q  <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            conflict_q  <= conflict_d;
            cpu_rdata_q <= cpu_rdata;
            dbg_rdata_q <= dbg_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a read-return scoreboard checked by a monitor process,
// plus inline checks of grants, stalls and the conflict counter.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .RESET_N(RESET_N),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    // Synchronous single-port RAM behind the arbiter.
    logic [31:0] ram [0:16383];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct packed {
        logic        is_dbg;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every read return is matched against the oldest expected response.
    always @(negedge clk) begin
        if (cpu_rvalid || dbg_rvalid) begin
            if (cpu_rvalid && dbg_rvalid) begin
                total++;
                bad++;
                $display("FAIL rvalid_both: cpu_rvalid=1 dbg_rvalid=1 required at most one");
            end else if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: rvalid with empty scoreboard, cpu=%0b dbg=%0b",
                         cpu_rvalid, dbg_rvalid);
            end else begin
                mon_e = sb.pop_front();
                check("rd_port_is_dbg", {31'd0, dbg_rvalid}, {31'd0, mon_e.is_dbg});
                check("rd_data", dbg_rvalid ? dbg_rdata : cpu_rdata, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        dbg_req = 1'b0;
        dbg_we  = 1'b0;
    endtask

    task automatic dbg_write(input logic [31:0] addr, input logic [31:0] data);
        cpu_req   = 1'b0;
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = addr;
        dbg_wdata = data;
        #1;
        check("dbg_wr_gnt", {31'd0, dbg_gnt}, 32'd1);
        tick();
        dbg_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] addr, input logic [31:0] exp);
        dbg_req  = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = addr;
        #1;
        check("cpu_rd_stall", {31'd0, cpu_stall}, 32'd0);
        check("cpu_rd_mem_en", {31'd0, mem_en}, 32'd1);
        sb.push_back({1'b0, exp});
        tick();
    endtask

    task automatic dbg_read(input logic [31:0] addr, input logic [31:0] exp);
        cpu_req  = 1'b0;
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = addr;
        #1;
        check("dbg_rd_gnt", {31'd0, dbg_gnt}, 32'd1);
        sb.push_back({1'b1, exp});
        tick();
    endtask

    // One cycle of CPU/debug contention with both read requests already driven.
    task automatic contend(input logic exp_force, input logic [31:0] cpu_exp,
                           input logic [31:0] dbg_exp);
        #1;
        check("contend_dbg_gnt", {31'd0, dbg_gnt}, {31'd0, exp_force});
        check("contend_cpu_stall", {31'd0, cpu_stall}, {31'd0, exp_force});
        if (exp_force) sb.push_back({1'b1, dbg_exp});
        else           sb.push_back({1'b0, cpu_exp});
        tick();
    endtask

    initial begin
        RESET_N   = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0104;
        cpu_wdata = 32'h1111_1111;
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 32'h0000_0200;
        dbg_wdata = 32'h2222_2222;

        // Outputs stay low during reset even with both requests raised.
        #12;
        check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        check("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        idle();
        RESET_N = 1'b1;
        tick();

        // Load the RAM through the debug port.
        dbg_write(32'h0000_0104, 32'hDEAD_BEEF);
        dbg_write(32'h0000_0300, 32'hA5A5_0001);
        dbg_write(32'h0000_0304, 32'hA5A5_0002);
        dbg_write(32'h0000_0308, 32'hA5A5_0003);
        dbg_write(32'h0000_030C, 32'hA5A5_0004);

        // Single CPU read; upper and byte-offset address bits must be dropped (-> word 0x41).
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0001_0107;
        #1;
        check("t1_mem_addr", {18'd0, mem_addr}, 32'h0000_0041);
        check("t1_stall", {31'd0, cpu_stall}, 32'd0);
        sb.push_back({1'b0, 32'hDEAD_BEEF});
        tick();
        idle();
        check("t1_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("t1_stall_after", {31'd0, cpu_stall}, 32'd0);
        tick();
        check("t1_rvalid_low", {31'd0, cpu_rvalid}, 32'd0);
        check("t1_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

        // Debug write followed immediately by a CPU read of the same word.
        dbg_write(32'h0000_0200, 32'h1234_5678);
        cpu_read(32'h0000_0200, 32'h1234_5678);

        // Alternating back-to-back reads on the two ports.
        cpu_read(32'h0000_0300, 32'hA5A5_0001);
        dbg_read(32'h0000_0304, 32'hA5A5_0002);
        cpu_read(32'h0000_0308, 32'hA5A5_0003);
        dbg_read(32'h0000_030C, 32'hA5A5_0004);
        idle();
        tick();

        // Starvation: four CPU wins, then a forced debug slot stalls the CPU.
        check("t2_conflict_start", {16'd0, conflict_cnt}, 32'd0);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0300;
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 32'h0000_0104;
        for (int i = 0; i < 4; i++) contend(1'b0, 32'hA5A5_0001, 32'h0);
        contend(1'b1, 32'h0, 32'hDEAD_BEEF);
        dbg_req = 1'b0;
        check("t2_conflict_one", {16'd0, conflict_cnt}, 32'd1);

        // Abandoned request restarts the wait count from zero.
        dbg_addr = 32'h0000_0308;
        dbg_req  = 1'b1;
        contend(1'b0, 32'hA5A5_0001, 32'h0);
        contend(1'b0, 32'hA5A5_0001, 32'h0);
        dbg_req = 1'b0;
        contend(1'b0, 32'hA5A5_0001, 32'h0);
        dbg_req = 1'b1;
        for (int i = 0; i < 4; i++) contend(1'b0, 32'hA5A5_0001, 32'h0);
        contend(1'b1, 32'h0, 32'hA5A5_0003);
        dbg_req = 1'b0;
        check("t5_conflict_two", {16'd0, conflict_cnt}, 32'd2);
        idle();
        tick();
        tick();

        // Reset during RD_CPU drops the pending return.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0104;
        tick();
        idle();
        check("t6_rvalid_pre", {31'd0, cpu_rvalid}, 32'd1);
        RESET_N = 1'b0;
        #1;
        check("t6_rvalid_rst", {31'd0, cpu_rvalid}, 32'd0);
        check("t6_cpu_rdata_rst", cpu_rdata, 32'd0);
        check("t6_dbg_rdata_rst", dbg_rdata, 32'd0);
        check("t6_conflict_rst", {16'd0, conflict_cnt}, 32'd0);
        check("t6_mem_en_rst", {31'd0, mem_en}, 32'd0);
        #2;
        RESET_N = 1'b1;
        tick();
        check("t6_conflict_after", {16'd0, conflict_cnt}, 32'd0);
        check("t6_rvalid_after", {31'd0, cpu_rvalid}, 32'd0);

        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
